load_sync_ctrl: RTL and testbench
=================================

# load_sync_ctrl

Input conditioning stage that sits directly upstream of the 8-bit counter. It synchronises the asynchronous pin-level `load_n`, `oe_n` and load-data inputs into `clk`, debounces `load_n`, and turns each qualified falling edge into a single registered load request with captured data. The request is presented to the counter over a valid/ready handshake. The block also produces the counter's output-enable, computed from the debounced `load_n` level and the synchronised `oe_n`.

## Interface
- `WIDTH`, 8: width of the load data and `load_value`.
- `SYNC_STAGES`, 2: synchroniser depth for all asynchronous inputs; must be ≥2.
- `DEBOUNCE_CYCLES`, 4: consecutive synchronised samples at the same level required to accept a level change; must be ≥1.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `load_n_async`  in  1  raw load request pin, active-low.
- `oe_n_async`  in  1  raw output-enable pin, active-low.
- `data_async`  in  WIDTH  raw load data; must be held stable from the `load_n` fall until `load_valid` rises.
- `load_valid`  out  1  registered load request to the counter.
- `load_value`  out  WIDTH  data captured for the pending or last load.
- `load_ready`  in  1  counter accepts the load on a clock edge where `load_valid` and `load_ready` are both high.
- `out_en`  out  1  registered output-enable to the counter pads.
- `load_overrun`  out  1  sticky flag; a qualified load was dropped.

## Operation
- **Synchronisers**
  - `load_n` and `oe_n` chains reset to 1; the data chain resets to 0.
  - Data bits are synchronised per bit. Coherence is guaranteed by the hold requirement on `data_async`.
- **Debounce FSM**, 4 states:
  - HIGH: debounced level = 1.
  - FALL_QUAL: counting low samples.
  - LOW: debounced level = 0.
  - RISE_QUAL: counting high samples.
- **Transitions**
  - HIGH → FALL_QUAL when the synchronised `load_n` is 0; count = 1.
  - FALL_QUAL: a 0 sample increments the count. A 1 sample returns to HIGH with count = 0 (glitch rejected).
  - FALL_QUAL → LOW on the cycle the count reaches DEBOUNCE_CYCLES. This is the qualified fall. With DEBOUNCE_CYCLES=1, HIGH goes directly to LOW on the first 0 sample.
  - LOW → RISE_QUAL on a 1 sample, then symmetric to FALL_QUAL. Reaching the count returns to HIGH; a 0 sample returns to LOW.
  - The debounce counter is sized clog2(DEBOUNCE_CYCLES+1) and never wraps.
- **Qualified fall**
  - If `load_valid` is 0, or a transfer completes on the same edge: `load_value` ← synchronised data and `load_valid` ← 1.
  - Otherwise: `load_value` is unchanged, `load_valid` stays 1, and `load_overrun` ← 1.
- **Handshake**
  - `load_valid` stays high until sampled with `load_ready` = 1, then clears on that edge.
  - `load_value` holds its value after the transfer.
  - `load_ready` is ignored while `load_valid` is 0.
- **Output enable:** `out_en` ← (debounced level == 1, i.e. state HIGH or RISE_QUAL... no: state HIGH or FALL_QUAL) AND (synchronised `oe_n` == 0). `oe_n` is not debounced.
- **Overrun:** `load_overrun` is cleared only by reset.
- Exactly one load request is produced per qualified fall. A rising edge never produces a load.

## Timing
- **Reset values:** `load_valid`=0, `load_value`=0, `out_en`=0, `load_overrun`=0, state HIGH, count 0.
- **Load latency**
  - `load_valid` rises SYNC_STAGES+DEBOUNCE_CYCLES rising edges after the first edge that samples `load_n_async` low (2+4 = 6 by default).
  - Data is captured from the synchronised data on that same edge.
- **Glitch rejection:** a low pulse seen for fewer than DEBOUNCE_CYCLES synchronised samples produces no load. Re-arming requires a debounced return to HIGH.
- **Back-to-back loads:** minimum spacing between qualified falls is 2×DEBOUNCE_CYCLES cycles of synchronised samples.
- **`out_en` latency:** follows `oe_n_async` after SYNC_STAGES+1 edges, and follows debounced level changes one edge after the state change.
- **Reset asserted mid-operation:** all state clears immediately, and any pending request is lost.
- **`load_n` held low across reset release:** the synchroniser starts at 1, so the held-low level is treated as a fall. One load occurs at SYNC_STAGES+DEBOUNCE_CYCLES edges after release.

## Test plan
- **Reset:** assert `rst_n` with inputs toggling → all outputs 0 during and after reset; no `load_valid` while `load_n_async`=1.
- **Clean load:** `data_async`=0xA5, drop `load_n_async`, `load_ready`=1 → `load_valid` high for exactly 1 cycle at edge 6, `load_value`=0xA5, `load_overrun`=0.
- **Glitch:** `load_n_async` low for 3 cycles then high → no `load_valid`. A following 5-cycle-low pulse → exactly one load.
- **Backpressure and overrun:**
  - `load_ready`=0; load 0x12, release, then load 0x34 → `load_valid` stays 1, `load_value`=0x12, `load_overrun`=1.
  - Raise `load_ready` → a single transfer of 0x12.
- **Same-edge transfer:** time the second qualified fall on the edge `load_ready` accepts the first → `load_value`=0x34, `load_valid` stays 1, `load_overrun`=0.
- **Output enable:**
  - `oe_n_async`=0 with `load_n_async`=1 → `out_en`=1 after 3 edges.
  - Hold `load_n_async` low → `out_en`=0 one edge after the debounced fall.
  - Reset pulse → `out_en`=0 immediately.

Source files
------------

// File: rtl/load_sync_ctrl.sv
// load_sync_ctrl
// Conditions the asynchronous load_n, oe_n and load-data pins for the
// 8-bit counter.
// - All inputs are synchronised into clk.
// - load_n is debounced, and each qualified falling edge becomes one
//   registered load request that is offered over a valid/ready handshake.
// - The counter's output enable is derived from the debounced load_n
//   level and the synchronised oe_n.

module load_sync_ctrl #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_n_async,
  input  logic             oe_n_async,
  input  logic [WIDTH-1:0] data_async,
  output logic             load_valid,
  output logic [WIDTH-1:0] load_value,
  input  logic             load_ready,
  output logic             out_en,
  output logic             load_overrun
);

  // The counter only ever has to reach DEBOUNCE_CYCLES, so it never wraps.
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_HIGH      = 2'd0,
    S_FALL_QUAL = 2'd1,
    S_LOW       = 2'd2,
    S_RISE_QUAL = 2'd3
  } state_t;

  // Synchroniser chains: index 0 is the first flop, the top index is the
  // output used by the rest of the block.
  logic [SYNC_STAGES-1:0]            load_n_sync_q;
  logic [SYNC_STAGES-1:0]            oe_n_sync_q;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] data_sync_q;

  logic             load_n_s;
  logic             oe_n_s;
  logic [WIDTH-1:0] data_s;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             qual_fall;
  logic             level_high;
  logic             xfer;

  logic             load_valid_q;
  logic [WIDTH-1:0] load_value_q;
  logic             out_en_q;
  logic             overrun_q;

  // Control chains reset to the inactive (high) pin level, so a pin held
  // low across reset release is seen as a fresh fall. Data resets to 0,
  // and each data bit is synchronised on its own; the hold requirement on
  // data_async keeps the captured word coherent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_n_sync_q <= '1;
      oe_n_sync_q   <= '1;
      data_sync_q   <= '0;
    end else begin
      load_n_sync_q <= {load_n_sync_q[SYNC_STAGES-2:0], load_n_async};
      oe_n_sync_q   <= {oe_n_sync_q[SYNC_STAGES-2:0], oe_n_async};
      data_sync_q   <= {data_sync_q[SYNC_STAGES-2:0], data_async};
    end
  end

  assign load_n_s = load_n_sync_q[SYNC_STAGES-1];
  assign oe_n_s   = oe_n_sync_q[SYNC_STAGES-1];
  assign data_s   = data_sync_q[SYNC_STAGES-1];

  assign cnt_inc    = cnt_q + CNT_ONE;
  assign level_high = (state_q == S_HIGH) || (state_q == S_FALL_QUAL);
  assign xfer       = load_valid_q && load_ready;

  // Debounce next-state. A level change is accepted only after
  // DEBOUNCE_CYCLES consecutive samples at the new level; any sample back
  // at the old level abandons the attempt. Entering LOW is the one event
  // that raises a load request.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    qual_fall = 1'b0;
    case (state_q)
      S_HIGH: begin
        if (!load_n_s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d   = S_LOW;
            cnt_d     = '0;
            qual_fall = 1'b1;
          end else begin
            state_d = S_FALL_QUAL;
            cnt_d   = CNT_ONE;
          end
        end
      end
      S_FALL_QUAL: begin
        if (load_n_s) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else if (cnt_inc == CNT_MAX) begin
          state_d   = S_LOW;
          cnt_d     = '0;
          qual_fall = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_LOW: begin
        if (load_n_s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = S_HIGH;
            cnt_d   = '0;
          end else begin
            state_d = S_RISE_QUAL;
            cnt_d   = CNT_ONE;
          end
        end
      end
      S_RISE_QUAL: begin
        if (!load_n_s) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else if (cnt_inc == CNT_MAX) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = S_HIGH;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state plus registered outputs.
  // - A qualified fall that meets a still-pending request marks an
  //   overrun and keeps the older data, unless the counter accepts the
  //   older request on that same edge.
  // - out_en tracks the registered debounced level, so it lags a level
  //   change by one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_HIGH;
      cnt_q        <= '0;
      load_valid_q <= 1'b0;
      load_value_q <= '0;
      out_en_q     <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      out_en_q <= level_high && !oe_n_s;
      if (qual_fall) begin
        if (!load_valid_q || xfer) begin
          load_value_q <= data_s;
          load_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (xfer) begin
        load_valid_q <= 1'b0;
      end
    end
  end

  assign load_valid   = load_valid_q;
  assign load_value   = load_value_q;
  assign out_en       = out_en_q;
  assign load_overrun = overrun_q;

endmodule

// File: tb/tb_load_sync_ctrl.sv
// Bench for load_sync_ctrl.
// - Expected load data goes into a queue as each pulse is driven.
// - A monitor pops that queue whenever the DUT hands a load to the
//   counter.
// Inputs change 1 ns after a rising edge; outputs are read 1 ns after a
// rising edge or at the falling edge.

module tb_load_sync_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_n_async;
  logic       oe_n_async;
  logic [7:0] data_async;
  logic       load_valid;
  logic [7:0] load_value;
  logic       load_ready;
  logic       out_en;
  logic       load_overrun;

  int         checks = 0;
  int         fails = 0;
  int         xferCount = 0;
  logic [7:0] expQ[$];

  typedef struct {
    int         lowCycles;
    logic [7:0] data;
    bit         expLoad;
  } vec_t;

  vec_t vecs[6];

  load_sync_ctrl #(
    .WIDTH(8),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .load_n_async(load_n_async),
    .oe_n_async(oe_n_async),
    .data_async(data_async),
    .load_valid(load_valid),
    .load_value(load_value),
    .load_ready(load_ready),
    .out_en(out_en),
    .load_overrun(load_overrun)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Compare one observed value against the expected value
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance n rising edges, then step 1 ns past the last edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulse reset; any request pending in the DUT is lost
  task automatic resetDut();
    rst_n = 1'b0;
    expQ.delete();
    tick(2);
    rst_n = 1'b1;
  endtask

  // Drive load_n low for lowCycles edges, then high for highCycles edges
  task automatic pulseLoad(input int lowCycles, input int highCycles);
    load_n_async = 1'b0;
    tick(lowCycles);
    load_n_async = 1'b1;
    tick(highCycles);
  endtask

  // Drive one table entry with the counter always ready
  task automatic applyStimulus(input vec_t v);
    data_async = v.data;
    load_ready = 1'b1;
    if (v.expLoad) expQ.push_back(v.data);
    pulseLoad(v.lowCycles, 12);
  endtask

  // Scoreboard: every accepted transfer must match the oldest expected load
  always @(negedge clk) begin
    if (rst_n && load_valid && load_ready) begin
      xferCount++;
      if (expQ.size() == 0) begin
        checks++;
        fails++;
        $display("[TB] FAIL unexpected_load: got value %0h, expected no transfer", load_value);
      end else begin
        checkOutput("xfer_data", {24'h0, load_value}, {24'h0, expQ.pop_front()});
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int expXfers;

    vecs[0] = '{lowCycles: 3, data: 8'h11, expLoad: 1'b0};
    vecs[1] = '{lowCycles: 5, data: 8'h22, expLoad: 1'b1};
    vecs[2] = '{lowCycles: 4, data: 8'h33, expLoad: 1'b1};
    vecs[3] = '{lowCycles: 1, data: 8'h44, expLoad: 1'b0};
    vecs[4] = '{lowCycles: 8, data: 8'h55, expLoad: 1'b1};
    vecs[5] = '{lowCycles: 2, data: 8'h66, expLoad: 1'b0};

    // Reset held while inputs toggle
    rst_n        = 1'b0;
    load_n_async = 1'b1;
    oe_n_async   = 1'b0;
    data_async   = 8'h00;
    load_ready   = 1'b0;
    for (int i = 0; i < 6; i++) begin
      load_n_async = ~load_n_async;
      data_async   = 8'($urandom);
      tick(1);
    end
    checkOutput("rst_valid", {31'h0, load_valid}, 0);
    checkOutput("rst_value", {24'h0, load_value}, 0);
    checkOutput("rst_out_en", {31'h0, out_en}, 0);
    checkOutput("rst_overrun", {31'h0, load_overrun}, 0);
    load_n_async = 1'b1;
    oe_n_async   = 1'b1;
    rst_n        = 1'b1;
    tick(10);
    checkOutput("idle_valid", {31'h0, load_valid}, 0);
    checkOutput("idle_out_en", {31'h0, out_en}, 0);

    // Clean load: valid rises on the 6th edge after the pin falls
    data_async = 8'hA5;
    load_ready = 1'b1;
    expQ.push_back(8'hA5);
    load_n_async = 1'b0;
    tick(5);
    checkOutput("clean_valid_edge5", {31'h0, load_valid}, 0);
    tick(1);
    checkOutput("clean_valid_edge6", {31'h0, load_valid}, 1);
    checkOutput("clean_value", {24'h0, load_value}, 32'hA5);
    tick(1);
    checkOutput("clean_valid_edge7", {31'h0, load_valid}, 0);
    checkOutput("clean_overrun", {31'h0, load_overrun}, 0);
    load_n_async = 1'b1;
    tick(12);

    // Table: glitches shorter than the debounce window produce no load
    expXfers = xferCount;
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      if (vecs[i].expLoad) expXfers++;
      checkOutput($sformatf("vec%0d_xfers", i), xferCount, expXfers);
    end
    checkOutput("vec_overrun", {31'h0, load_overrun}, 0);
    checkOutput("vec_value_held", {24'h0, load_value}, 32'h55);

    // Backpressure: second fall while the first is pending sets overrun
    load_ready = 1'b0;
    data_async = 8'h12;
    expQ.push_back(8'h12);
    pulseLoad(6, 10);
    checkOutput("bp_valid1", {31'h0, load_valid}, 1);
    checkOutput("bp_value1", {24'h0, load_value}, 32'h12);
    checkOutput("bp_overrun1", {31'h0, load_overrun}, 0);
    data_async = 8'h34;
    pulseLoad(6, 10);
    checkOutput("bp_valid2", {31'h0, load_valid}, 1);
    checkOutput("bp_value2", {24'h0, load_value}, 32'h12);
    checkOutput("bp_overrun2", {31'h0, load_overrun}, 1);
    expXfers = xferCount + 1;
    load_ready = 1'b1;
    tick(3);
    checkOutput("bp_xfers", xferCount, expXfers);
    checkOutput("bp_valid_clear", {31'h0, load_valid}, 0);
    checkOutput("bp_value_hold", {24'h0, load_value}, 32'h12);
    checkOutput("bp_overrun_sticky", {31'h0, load_overrun}, 1);
    resetDut();
    checkOutput("bp_overrun_reset", {31'h0, load_overrun}, 0);
    tick(4);

    // Same-edge transfer: second qualified fall lands on the accepting edge
    load_ready = 1'b0;
    data_async = 8'h12;
    expQ.push_back(8'h12);
    pulseLoad(6, 12);
    data_async = 8'h34;
    expQ.push_back(8'h34);
    load_n_async = 1'b0;
    tick(5);
    load_ready = 1'b1;
    tick(1);
    checkOutput("same_valid", {31'h0, load_valid}, 1);
    checkOutput("same_value", {24'h0, load_value}, 32'h34);
    checkOutput("same_overrun", {31'h0, load_overrun}, 0);
    tick(1);
    checkOutput("same_valid_clear", {31'h0, load_valid}, 0);
    load_n_async = 1'b1;
    tick(12);

    // Output enable from oe_n: three edges of latency
    oe_n_async = 1'b0;
    tick(2);
    checkOutput("oe_edge2", {31'h0, out_en}, 0);
    tick(1);
    checkOutput("oe_edge3", {31'h0, out_en}, 1);

    // Debounced fall drops out_en one edge after the state change
    data_async = 8'h5A;
    expQ.push_back(8'h5A);
    load_n_async = 1'b0;
    tick(6);
    checkOutput("oe_fall_edge6", {31'h0, out_en}, 1);
    tick(1);
    checkOutput("oe_fall_edge7", {31'h0, out_en}, 0);
    load_n_async = 1'b1;
    tick(12);
    checkOutput("oe_rearmed", {31'h0, out_en}, 1);

    // Asynchronous reset clears out_en immediately; load_n held low across
    // release yields exactly one load 6 edges later
    load_n_async = 1'b0;
    rst_n = 1'b0;
    expQ.delete();
    #1;
    checkOutput("oe_reset_now", {31'h0, out_en}, 0);
    tick(2);
    data_async = 8'hC3;
    expQ.push_back(8'hC3);
    rst_n = 1'b1;
    tick(5);
    checkOutput("held_low_edge5", {31'h0, load_valid}, 0);
    tick(1);
    checkOutput("held_low_edge6", {31'h0, load_valid}, 1);
    checkOutput("held_low_value", {24'h0, load_value}, 32'hC3);
    tick(10);
    load_n_async = 1'b1;
    tick(12);

    checkOutput("queue_drained", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
